// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard flags in, pipeline enable/flush controls out.
// master: hazard/memory side; slave: the stall controller.
interface pipeline_stall_ctrl_if;
   logic load_rs_D;
   logic load_rt_D;
   logic branch_stall_D;
   logic branch_taken_D;
   logic jump_D;
   logic imem_busy;
   logic dmem_busy;
   logic pc_en;
   logic if_id_en;
   logic if_id_flush;
   logic id_ex_en;
   logic id_ex_flush;
   logic ex_mem_en;
   logic mem_wb_en;
   logic mem_wb_flush;
   logic mem_timeout;

   modport master (
      output load_rs_D, load_rt_D, branch_stall_D,
      output branch_taken_D, jump_D, imem_busy, dmem_busy,
      input  pc_en, if_id_en, if_id_flush,
      input  id_ex_en, id_ex_flush, ex_mem_en,
      input  mem_wb_en, mem_wb_flush, mem_timeout
   );

   modport slave (
      input  load_rs_D, load_rt_D, branch_stall_D,
      input  branch_taken_D, jump_D, imem_busy, dmem_busy,
      output pc_en, if_id_en, if_id_flush,
      output id_ex_en, id_ex_flush, ex_mem_en,
      output mem_wb_en, mem_wb_flush, mem_timeout
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller with memory-wait sequencing,
// fetch-redirect capture, dmem watchdog and perf counters.
// Ports: clk, rst_n (sync, active-low); bus (slave): hazard flags in,
// stage enables/flushes and mem_timeout out; stall_cnt/flush_cnt out.
module pipeline_stall_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_stall_ctrl_if.slave bus,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] ERROR    = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [WD_W-1:0]      wd_q, wd_d;
   logic                 redir_q, redir_d;
   logic                 tmo_q, tmo_d;
   logic [CNT_WIDTH-1:0] stall_q, flush_q;

   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_fl, id_ex_fl, mem_wb_fl;
   logic hazard, redirect;

   assign hazard   = bus.load_rs_D | bus.load_rt_D
                   | bus.branch_stall_D;
   assign redirect = bus.branch_taken_D | bus.jump_D;

   always_comb begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if_id_fl  = 1'b0;
      id_ex_fl  = 1'b0;
      mem_wb_fl = 1'b0;
      state_d   = state_q;
      wd_d      = wd_q;
      redir_d   = redir_q;
      tmo_d     = tmo_q;
      if (!rst_n) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
         if_id_fl  = 1'b1;
         id_ex_fl  = 1'b1;
         mem_wb_fl = 1'b1;
      end else if (state_q == ERROR) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (bus.dmem_busy) begin
         // MEM_WB keeps clocking a bubble so the held
         // instruction is not written back twice.
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_fl = 1'b1;
         wd_d      = wd_q + WD_W'(1);
         state_d   = MEM_WAIT;
         if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ERROR;
            tmo_d   = 1'b1;
         end
      end else begin
         wd_d    = '0;
         state_d = RUN;
         if (hazard) begin
            // branch/jump use stale operands here: ignore
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_fl = 1'b1;
         end else if (bus.imem_busy) begin
            pc_en    = 1'b0;
            if_id_fl = 1'b1;
            if (redirect) redir_d = 1'b1;
         end else begin
            // a pending redirect squashes the stale fetch
            if (redirect || redir_q) if_id_fl = 1'b1;
            redir_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         wd_q    <= '0;
         redir_q <= 1'b0;
         tmo_q   <= 1'b0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         redir_q <= redir_d;
         tmo_q   <= tmo_d;
         if (!pc_en && stall_q != '1)
            stall_q <= stall_q + 1'b1;
         if ((if_id_fl || id_ex_fl) && flush_q != '1)
            flush_q <= flush_q + 1'b1;
      end
   end

   assign bus.pc_en        = pc_en;
   assign bus.if_id_en     = if_id_en;
   assign bus.if_id_flush  = if_id_fl;
   assign bus.id_ex_en     = id_ex_en;
   assign bus.id_ex_flush  = id_ex_fl;
   assign bus.ex_mem_en    = ex_mem_en;
   assign bus.mem_wb_en    = mem_wb_en;
   assign bus.mem_wb_flush = mem_wb_fl;
   assign bus.mem_timeout  = tmo_q;
   assign stall_cnt        = stall_q;
   assign flush_cnt        = flush_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl (TIMEOUT_CYCLES=4,
// CNT_WIDTH=4 so watchdog and counter saturation are reachable).
module tb_pipeline_stall_ctrl;

   typedef struct packed {
      logic [4:0] en;
      logic [2:0] fl;
      logic       tmo;
      logic [3:0] sc;
      logic [3:0] fc;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] stall_cnt, flush_cnt;
   obs_t obs;
   obs_t sb[$];
   int vectors = 0;
   int miscompares = 0;

   pipeline_stall_ctrl_if bus();

   pipeline_stall_ctrl #(
      .TIMEOUT_CYCLES(4),
      .CNT_WIDTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   assign obs = {bus.pc_en, bus.if_id_en, bus.id_ex_en,
                 bus.ex_mem_en, bus.mem_wb_en,
                 bus.if_id_flush, bus.id_ex_flush,
                 bus.mem_wb_flush, bus.mem_timeout,
                 stall_cnt, flush_cnt};

   function automatic obs_t e(input logic [4:0] en,
                              input logic [2:0] fl,
                              input logic t,
                              input int sc, input int fc);
      logic [3:0] s, f;
      s = sc[3:0];
      f = fc[3:0];
      return {en, fl, t, s, f};
   endfunction

   // in = {rst_n, rs, rt, bstall, btaken, jump, imem, dmem}
   task automatic drive(input logic [7:0] in, input obs_t ex);
      @(negedge clk);
      rst_n              = in[7];
      bus.load_rs_D      = in[6];
      bus.load_rt_D      = in[5];
      bus.branch_stall_D = in[4];
      bus.branch_taken_D = in[3];
      bus.jump_D         = in[2];
      bus.imem_busy      = in[1];
      bus.dmem_busy      = in[0];
      sb.push_back(ex);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] ins [3];
      obs_t exps [3];
      obs_t got, want;
      ins  = '{8'h00, 8'h00, 8'h80};
      exps = '{e(5'h00, 3'h7, 0, 0, 0),
               e(5'h00, 3'h7, 0, 0, 0),
               e(5'h1F, 3'h0, 0, 0, 0)};
      for (int i = 0; i < 3; i++) begin
         drive(ins[i], exps[i]);
         got  = obs;
         want = sb.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL reset[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_load_stall();
      logic [7:0] ins [2];
      obs_t exps [2];
      obs_t got, want;
      ins  = '{8'hA0, 8'h80};
      exps = '{e(5'h07, 3'h2, 0, 0, 0),
               e(5'h1F, 3'h0, 0, 1, 1)};
      for (int i = 0; i < 2; i++) begin
         drive(ins[i], exps[i]);
         got  = obs;
         want = sb.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL load_stall[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   // second burst would trip the watchdog if wd_cnt were not cleared
   task automatic test_dmem_wait();
      logic [7:0] ins [8];
      obs_t exps [8];
      obs_t got, want;
      ins  = '{8'h81, 8'h81, 8'h81, 8'h80,
               8'h81, 8'h81, 8'h81, 8'h80};
      exps = '{e(5'h01, 3'h1, 0, 1, 1),
               e(5'h01, 3'h1, 0, 2, 1),
               e(5'h01, 3'h1, 0, 3, 1),
               e(5'h1F, 3'h0, 0, 4, 1),
               e(5'h01, 3'h1, 0, 4, 1),
               e(5'h01, 3'h1, 0, 5, 1),
               e(5'h01, 3'h1, 0, 6, 1),
               e(5'h1F, 3'h0, 0, 7, 1)};
      for (int i = 0; i < 8; i++) begin
         drive(ins[i], exps[i]);
         got  = obs;
         want = sb.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL dmem_wait[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_redirect();
      logic [7:0] ins [5];
      obs_t exps [5];
      obs_t got, want;
      ins  = '{8'h86, 8'h80, 8'h80, 8'h88, 8'h80};
      exps = '{e(5'h0F, 3'h4, 0, 7, 1),
               e(5'h1F, 3'h4, 0, 8, 2),
               e(5'h1F, 3'h0, 0, 8, 3),
               e(5'h1F, 3'h4, 0, 8, 3),
               e(5'h1F, 3'h0, 0, 8, 4)};
      for (int i = 0; i < 5; i++) begin
         drive(ins[i], exps[i]);
         got  = obs;
         want = sb.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL redirect[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_priority();
      logic [7:0] ins [7];
      obs_t exps [7];
      obs_t got, want;
      ins  = '{8'hCA, 8'h80, 8'h83, 8'h82,
               8'h80, 8'h94, 8'h80};
      exps = '{e(5'h07, 3'h2, 0, 8, 4),
               e(5'h1F, 3'h0, 0, 9, 5),
               e(5'h01, 3'h1, 0, 9, 5),
               e(5'h0F, 3'h4, 0, 10, 5),
               e(5'h1F, 3'h0, 0, 11, 6),
               e(5'h07, 3'h2, 0, 11, 6),
               e(5'h1F, 3'h0, 0, 12, 7)};
      for (int i = 0; i < 7; i++) begin
         drive(ins[i], exps[i]);
         got  = obs;
         want = sb.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL priority[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_saturation();
      logic [7:0] ins [7];
      obs_t exps [7];
      obs_t got, want;
      ins  = '{8'hA0, 8'hA0, 8'hA0, 8'hA0,
               8'hA0, 8'hA0, 8'h80};
      exps = '{e(5'h07, 3'h2, 0, 12, 7),
               e(5'h07, 3'h2, 0, 13, 8),
               e(5'h07, 3'h2, 0, 14, 9),
               e(5'h07, 3'h2, 0, 15, 10),
               e(5'h07, 3'h2, 0, 15, 11),
               e(5'h07, 3'h2, 0, 15, 12),
               e(5'h1F, 3'h0, 0, 15, 13)};
      for (int i = 0; i < 7; i++) begin
         drive(ins[i], exps[i]);
         got  = obs;
         want = sb.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL saturation[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_watchdog();
      logic [7:0] ins [9];
      obs_t exps [9];
      obs_t got, want;
      ins  = '{8'h00, 8'h81, 8'h81, 8'h81, 8'h81,
               8'hFF, 8'h80, 8'h00, 8'h80};
      exps = '{e(5'h00, 3'h7, 0, 15, 13),
               e(5'h01, 3'h1, 0, 0, 0),
               e(5'h01, 3'h1, 0, 1, 0),
               e(5'h01, 3'h1, 0, 2, 0),
               e(5'h01, 3'h1, 0, 3, 0),
               e(5'h00, 3'h0, 1, 4, 0),
               e(5'h00, 3'h0, 1, 5, 0),
               e(5'h00, 3'h7, 1, 6, 0),
               e(5'h1F, 3'h0, 0, 0, 0)};
      for (int i = 0; i < 9; i++) begin
         drive(ins[i], exps[i]);
         got  = obs;
         want = sb.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL watchdog[%0d]: got %h want %h", i, got, want);
         end
      end
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.load_rs_D      = 1'b0;
      bus.load_rt_D      = 1'b0;
      bus.branch_stall_D = 1'b0;
      bus.branch_taken_D = 1'b0;
      bus.jump_D         = 1'b0;
      bus.imem_busy      = 1'b0;
      bus.dmem_busy      = 1'b0;
      test_reset();
      test_load_stall();
      test_dmem_wait();
      test_redirect();
      test_priority();
      test_saturation();
      test_watchdog();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
